// File: rtl/pwm_compare_deadtime_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_compare_deadtime_if
//  Brief    : Bus bundle between the carrier generator / register side
//             (master) and the compare + dead-time stage (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface pwm_compare_deadtime_if #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 10
);
    logic [CNT_W-1:0] carrier;
    logic             mask_event;
    logic [CNT_W-1:0] compare_in;
    logic             compare_wr;
    logic [DT_W-1:0]  deadtime;
    logic             pwm_on;
    logic             polarity;
    logic             pwm_h;
    logic             pwm_l;
    logic [CNT_W-1:0] compare_active;
    logic             update_pending;

    modport master (
        output carrier, mask_event, compare_in, compare_wr, deadtime, pwm_on, polarity,
        input  pwm_h, pwm_l, compare_active, update_pending
    );

    modport slave (
        input  carrier, mask_event, compare_in, compare_wr, deadtime, pwm_on, polarity,
        output pwm_h, pwm_l, compare_active, update_pending
    );
endinterface
`default_nettype wire

// File: rtl/pwm_compare_deadtime.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_compare_deadtime
//  Brief    : Double-buffered carrier compare followed by a complementary
//             high/low gate driver with programmable dead band.
//             Optional fault trip enabled by defining PWM_FAULT_TRIP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_compare_deadtime #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    pwm_compare_deadtime_if.slave bus
`ifdef PWM_FAULT_TRIP_EN
    ,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic                  fault_latched
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        L_ON  = 3'd1,
        DT_LH = 3'd2,
        H_ON  = 3'd3,
        DT_HL = 3'd4
    } state_t;

    logic [CNT_W-1:0] shadow_q,         shadow_d;
    logic [CNT_W-1:0] compare_active_q, compare_active_d;
    logic             update_pending_q, update_pending_d;
    logic             cmp_q,            cmp_d;
    state_t           state_q,          state_d;
    logic [DT_W-1:0]  dt_cnt_q,         dt_cnt_d;
    logic             drive_h_q,        drive_h_d;
    logic             drive_l_q,        drive_l_d;
    logic             hold_idle;

`ifdef PWM_FAULT_TRIP_EN
    logic             fault_latched_q,  fault_latched_d;

    // Fault latch: set wins over clear; the FSM is held off while a fault is
    // present or still latched (the clearing edge itself keeps IDLE).
    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end
    end

    // Fault latch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_latched_q <= 1'b0;
        end else begin
            fault_latched_q <= fault_latched_d;
        end
    end

    assign hold_idle     = fault | fault_latched_q;
    assign fault_latched = fault_latched_q;
`else
    assign hold_idle     = 1'b0;
`endif

    // Shadow/active compare buffering; a write coinciding with the update
    // strobe bypasses the shadow so the new value is not lost for a period.
    always_comb begin
        shadow_d         = shadow_q;
        compare_active_d = compare_active_q;
        update_pending_d = update_pending_q;
        if (bus.compare_wr && bus.mask_event) begin
            shadow_d         = bus.compare_in;
            compare_active_d = bus.compare_in;
            update_pending_d = 1'b0;
        end else if (bus.compare_wr) begin
            shadow_d         = bus.compare_in;
            update_pending_d = 1'b1;
        end else if (bus.mask_event && update_pending_q) begin
            compare_active_d = shadow_q;
            update_pending_d = 1'b0;
        end
    end

    // Compare buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q         <= '0;
            compare_active_q <= '0;
            update_pending_q <= 1'b0;
        end else begin
            shadow_q         <= shadow_d;
            compare_active_q <= compare_active_d;
            update_pending_q <= update_pending_d;
        end
    end

    // Raw PWM reference: unsigned compare, so 0 gives 0% and any value above
    // the carrier peak gives 100%.
    always_comb begin
        cmp_d = (bus.carrier < compare_active_q);
    end

    // Registered raw reference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    // Gate FSM next state: every switch-on passes through a dead state whose
    // counter is loaded on entry; a reference that flips back during the dead
    // band returns to the side it came from without ever turning on.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.pwm_on) begin
                    state_d  = cmp_q ? DT_LH : DT_HL;
                    dt_cnt_d = bus.deadtime;
                end
            end
            L_ON: begin
                if (cmp_q) begin
                    state_d  = DT_LH;
                    dt_cnt_d = bus.deadtime;
                end
            end
            H_ON: begin
                if (!cmp_q) begin
                    state_d  = DT_HL;
                    dt_cnt_d = bus.deadtime;
                end
            end
            DT_LH: begin
                if (!cmp_q) begin
                    state_d = L_ON;
                end else if (dt_cnt_q <= DT_W'(1)) begin
                    state_d = H_ON;
                end else begin
                    dt_cnt_d = dt_cnt_q - DT_W'(1);
                end
            end
            DT_HL: begin
                if (cmp_q) begin
                    state_d = H_ON;
                end else if (dt_cnt_q <= DT_W'(1)) begin
                    state_d = L_ON;
                end else begin
                    dt_cnt_d = dt_cnt_q - DT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!bus.pwm_on || hold_idle) begin
            state_d  = IDLE;
            dt_cnt_d = dt_cnt_q;
        end
    end

    // Output decode from the next state so the gates switch on the same edge
    // as the state register; h and l can never both be driven.
    always_comb begin
        drive_h_d = (state_d == H_ON);
        drive_l_d = (state_d == L_ON);
    end

    // FSM, dead-time counter and gate decode registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dt_cnt_q  <= '0;
            drive_h_q <= 1'b0;
            drive_l_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dt_cnt_q  <= dt_cnt_d;
            drive_h_q <= drive_h_d;
            drive_l_q <= drive_l_d;
        end
    end

    // Polarity is a static configuration applied after the registered decode,
    // which also yields the inactive level while reset is held.
    assign bus.pwm_h          = drive_h_q ^ bus.polarity;
    assign bus.pwm_l          = drive_l_q ^ bus.polarity;
    assign bus.compare_active = compare_active_q;
    assign bus.update_pending = update_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_compare_deadtime.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_compare_deadtime
//  Brief    : Directed self-checking bench for pwm_compare_deadtime.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_compare_deadtime;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pwm_compare_deadtime_if #(.CNT_W(16), .DT_W(10)) bus ();

`ifdef PWM_FAULT_TRIP_EN
    logic fault;
    logic fault_clr;
    logic fault_latched;
`endif

    pwm_compare_deadtime #(.CNT_W(16), .DT_W(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave)
`ifdef PWM_FAULT_TRIP_EN
        ,
        .fault         (fault),
        .fault_clr     (fault_clr),
        .fault_latched (fault_latched)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Load a compare value straight into the active register.
    task automatic set_cmp(input logic [15:0] v);
        bus.compare_in = v;
        bus.compare_wr = 1'b1;
        bus.mask_event = 1'b1;
        step(1);
        bus.compare_wr = 1'b0;
        bus.mask_event = 1'b0;
    endtask

    // Up/down carrier 0..0x3FF..1, period 2046 clocks.
    function automatic logic [15:0] tri_val(input int t);
        int p;
        p = t % 2046;
        return (p <= 1023) ? 16'(p) : 16'(2046 - p);
    endfunction

    initial begin
        int hcnt, lcnt, dcnt, ovl, run, maxrun;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.carrier = '0;
        bus.mask_event = 1'b0;
        bus.compare_in = '0;
        bus.compare_wr = 1'b0;
        bus.deadtime = '0;
        bus.pwm_on = 1'b0;
        bus.polarity = 1'b0;
`ifdef PWM_FAULT_TRIP_EN
        fault = 1'b0;
        fault_clr = 1'b0;
`endif
        step(3);
        check("rst_h", 32'(bus.pwm_h), 32'd0);
        check("rst_l", 32'(bus.pwm_l), 32'd0);
        check("rst_active", 32'(bus.compare_active), 32'd0);
        check("rst_pending", 32'(bus.update_pending), 32'd0);
        reset = 1'b0;
        step(1);

        // Shadow write without update strobe.
        bus.compare_in = 16'h0100;
        bus.compare_wr = 1'b1;
        step(1);
        bus.compare_wr = 1'b0;
        check("wr_active", 32'(bus.compare_active), 32'h0);
        check("wr_pending", 32'(bus.update_pending), 32'd1);
        step(2);
        check("wr_active_hold", 32'(bus.compare_active), 32'h0);
        // Update strobe transfers the shadow.
        bus.mask_event = 1'b1;
        step(1);
        bus.mask_event = 1'b0;
        check("mask_active", 32'(bus.compare_active), 32'h0100);
        check("mask_pending", 32'(bus.update_pending), 32'd0);
        // Write and strobe together bypass the shadow.
        set_cmp(16'h0200);
        check("bypass_active", 32'(bus.compare_active), 32'h0200);
        check("bypass_pending", 32'(bus.update_pending), 32'd0);
        // Strobe with nothing pending changes nothing.
        bus.compare_in = 16'h0055;
        bus.mask_event = 1'b1;
        step(1);
        bus.mask_event = 1'b0;
        check("nopend_active", 32'(bus.compare_active), 32'h0200);

        // Edge latency with zero dead time.
        bus.carrier = 16'h0300;
        bus.deadtime = 10'd0;
        bus.pwm_on = 1'b1;
        step(6);
        check("lat_l_on", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b01);
        bus.carrier = 16'h0100;
        step(1);
        check("lat_e1", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b01);
        step(1);
        check("lat_e2_dead", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b00);
        step(1);
        check("lat_e3_h_on", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b10);

        // Up/down carrier, compare 0x200, dead time 10.
        bus.deadtime = 10'd10;
        for (int t = 0; t < 2 * 2046; t++) begin
            bus.carrier = tri_val(t);
            step(1);
        end
        hcnt = 0; lcnt = 0; dcnt = 0; ovl = 0; run = 0; maxrun = 0;
        for (int t = 2 * 2046; t < 3 * 2046; t++) begin
            bus.carrier = tri_val(t);
            step(1);
            if (bus.pwm_h) hcnt++;
            if (bus.pwm_l) lcnt++;
            if (bus.pwm_h && bus.pwm_l) ovl++;
            if (!bus.pwm_h && !bus.pwm_l) begin
                dcnt++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("tri_h_cycles", 32'(hcnt), 32'd1013);
        check("tri_l_cycles", 32'(lcnt), 32'd1013);
        check("tri_dead_cycles", 32'(dcnt), 32'd20);
        check("tri_overlap", 32'(ovl), 32'd0);
        check("tri_gap_len", 32'(maxrun), 32'd10);

        // Reference pulse shorter than the dead band never turns H on.
        bus.carrier = 16'h0300;
        step(40);
        check("short_pre_l", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b01);
        hcnt = 0; lcnt = 0;
        bus.carrier = 16'h0100;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) bus.carrier = 16'h0300;
            step(1);
            if (bus.pwm_h) hcnt++;
            if (!bus.pwm_l) lcnt++;
        end
        check("short_h_never", 32'(hcnt), 32'd0);
        check("short_l_off_len", 32'(lcnt), 32'd5);
        check("short_post_l", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b01);

        // 0% and 100% duty extremes.
        set_cmp(16'h0000);
        bus.carrier = 16'h0000;
        step(20);
        check("duty0", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b01);
        set_cmp(16'h0400);
        bus.carrier = 16'h03FF;
        step(20);
        check("duty100", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b10);

        // Asynchronous reset in the middle of H_ON.
        reset = 1'b1;
        bus.pwm_on = 1'b0;
        bus.polarity = 1'b1;
        bus.carrier = 16'h0300;
        #1;
        check("midrst_out", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b11);
        check("midrst_active", 32'(bus.compare_active), 32'h0);
        step(1);
        reset = 1'b0;
        step(2);

        // Inverted polarity: idle high, enter through a 3-cycle dead state.
        check("pol_idle", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b11);
        bus.deadtime = 10'd3;
        bus.pwm_on = 1'b1;
        step(1);
        check("pol_dt_first", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b11);
        step(2);
        check("pol_dt_last", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b11);
        step(1);
        check("pol_l_on", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b10);
        bus.pwm_on = 1'b0;
        step(1);
        check("pol_off", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b11);

`ifdef PWM_FAULT_TRIP_EN
        // Fault trip from H_ON, held until cleared.
        bus.polarity = 1'b0;
        set_cmp(16'h0200);
        bus.deadtime = 10'd2;
        bus.carrier = 16'h0100;
        bus.pwm_on = 1'b1;
        step(10);
        check("flt_pre_h", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b10);
        fault = 1'b1;
        step(1);
        fault = 1'b0;
        check("flt_trip_out", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b00);
        check("flt_latched", 32'(fault_latched), 32'd1);
        step(5);
        check("flt_held", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b00);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("flt_clr_latch", 32'(fault_latched), 32'd0);
        check("flt_clr_edge", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b00);
        step(6);
        check("flt_recover", {30'd0, bus.pwm_h, bus.pwm_l}, 32'b10);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
